// File: rtl/sram_arb.sv
// Two-port arbiter in front of a single-port SRAM with per-port read response buffering.
// SRAM_ARB_RR_EN selects round-robin arbitration; fixed priority (port 0) otherwise.
module sram_arb #(
  parameter int AW = 15,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rq0_vld,
  output logic          rq0_rdy,
  input  logic          rq0_wen,
  input  logic [AW-1:0] rq0_addr,
  input  logic [DW-1:0] rq0_wdata,
  input  logic          rq1_vld,
  output logic          rq1_rdy,
  input  logic          rq1_wen,
  input  logic [AW-1:0] rq1_addr,
  input  logic [DW-1:0] rq1_wdata,
  output logic          rs0_vld,
  input  logic          rs0_rdy,
  output logic [DW-1:0] rs0_rdata,
  output logic          rs1_vld,
  input  logic          rs1_rdy,
  output logic [DW-1:0] rs1_rdata,
  output logic          sram_cs,
  output logic          sram_wen,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } st_e;

  st_e           st_q   [2];
  logic [DW-1:0] hold_q [2];
  logic [DW-1:0] rdat   [2];

  logic [1:0] vld, wen, rsr;
  logic [1:0] rsv, take, el, gnt, rd;

  assign vld = {rq1_vld, rq0_vld};
  assign wen = {rq1_wen, rq0_wen};
  assign rsr = {rs1_rdy, rs0_rdy};

  // A read may only issue once the port's previous response is gone or leaving
  always_comb begin
    rsv  = '0;
    take = '0;
    el   = '0;
    for (int i = 0; i < 2; i++) begin
      rsv[i]  = !rst && (st_q[i] != IDLE);
      take[i] = rsv[i] && rsr[i];
      el[i]   = !rst && vld[i] &&
                (wen[i] || (st_q[i] == IDLE) || take[i]);
    end
  end

`ifdef SRAM_ARB_RR_EN
  logic last_q;

  always_comb begin
    gnt = el;
    if (el == 2'b11)
      gnt = last_q ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk) begin
    if (rst)
      last_q <= 1'b1;
    else if (|gnt)
      last_q <= gnt[1];
  end
`else
  always_comb begin
    gnt = el;
    if (el[0])
      gnt = 2'b01;
  end
`endif

  assign rd      = gnt & ~wen;
  assign rq0_rdy = gnt[0];
  assign rq1_rdy = gnt[1];

  always_comb begin
    sram_cs    = 1'b0;
    sram_wen   = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    unique case (1'b1)
      gnt[0]: begin
        sram_cs    = 1'b1;
        sram_wen   = rq0_wen;
        sram_addr  = rq0_addr;
        sram_wdata = rq0_wdata;
      end
      gnt[1]: begin
        sram_cs    = 1'b1;
        sram_wen   = rq1_wen;
        sram_addr  = rq1_addr;
        sram_wdata = rq1_wdata;
      end
      default: ;
    endcase
  end

  // WAIT forwards the SRAM output directly; HOLD replays the captured word
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rdat[i] = '0;
      unique case (1'b1)
        rsv[i] && (st_q[i] == WAIT): rdat[i] = sram_rdata;
        rsv[i] && (st_q[i] == HOLD): rdat[i] = hold_q[i];
        default: ;
      endcase
    end
  end

  assign rs0_vld   = rsv[0];
  assign rs1_vld   = rsv[1];
  assign rs0_rdata = rdat[0];
  assign rs1_rdata = rdat[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]   <= IDLE;
        hold_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        unique case (st_q[i])
          IDLE: if (rd[i]) st_q[i] <= WAIT;
          WAIT: begin
            if (rsr[i]) begin
              st_q[i] <= rd[i] ? WAIT : IDLE;
            end else begin
              st_q[i]   <= HOLD;
              hold_q[i] <= sram_rdata;
            end
          end
          HOLD: if (rsr[i]) st_q[i] <= rd[i] ? WAIT : IDLE;
          default: st_q[i] <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sram_arb.sv
// Bench for sram_arb: directed scenarios then random traffic,
// all cycles compared against a transaction-level reference model.
module tb_sram_arb;
  localparam int AW = 15;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]    vld, wen, rsr;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wd   [2];

  logic          rq0_rdy, rq1_rdy, rs0_vld, rs1_vld;
  logic [DW-1:0] rs0_rdata, rs1_rdata;
  logic          sram_cs, sram_wen;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;

  sram_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .rq0_vld(vld[0]), .rq0_rdy(rq0_rdy), .rq0_wen(wen[0]),
    .rq0_addr(addr[0]), .rq0_wdata(wd[0]),
    .rq1_vld(vld[1]), .rq1_rdy(rq1_rdy), .rq1_wen(wen[1]),
    .rq1_addr(addr[1]), .rq1_wdata(wd[1]),
    .rs0_vld(rs0_vld), .rs0_rdy(rsr[0]), .rs0_rdata(rs0_rdata),
    .rs1_vld(rs1_vld), .rs1_rdy(rsr[1]), .rs1_rdata(rs1_rdata),
    .sram_cs(sram_cs), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
    logic [DW-1:0] av;
    av = DW'(a);
    if (a == 6) return 32'h1234_5678;
    return (av * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Environment SRAM: registered read, written contents override the pattern
  logic [DW-1:0] smem [0:(1<<AW)-1];
  bit            swv  [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_wen) begin
        smem[sram_addr] <= sram_wdata;
        swv[sram_addr]  <= 1'b1;
      end else begin
        sram_rdata <= swv[sram_addr] ? smem[sram_addr]
                                     : init_val(sram_addr);
      end
    end
  end

  // Reference model: one-deep outstanding response per port
  logic [DW-1:0] rmem [int];
  bit            ov [2] = '{1'b0, 1'b0};
  logic [DW-1:0] od [2];
  bit            last = 1'b1;

  int checks = 0;
  int failures = 0;

  function automatic logic [DW-1:0] rget(logic [AW-1:0] a);
    if (rmem.exists(int'(a))) return rmem[int'(a)];
    return init_val(a);
  endfunction

  task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic tick();
    bit tk [2];
    bit el [2];
    int w;
    @(negedge clk);
    w = -1;
    tk = '{1'b0, 1'b0};
    el = '{1'b0, 1'b0};
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        tk[i] = ov[i] && rsr[i];
        el[i] = vld[i] && (wen[i] || !ov[i] || tk[i]);
      end
      if (el[0] && el[1]) begin
`ifdef SRAM_ARB_RR_EN
        w = last ? 0 : 1;
`else
        w = 0;
`endif
      end else if (el[0]) w = 0;
      else if (el[1]) w = 1;
    end
    chk("rq0_rdy", rq0_rdy, w == 0);
    chk("rq1_rdy", rq1_rdy, w == 1);
    chk("sram_cs", sram_cs, w >= 0);
    chk("sram_wen", sram_wen, (w >= 0) ? wen[w] : 1'b0);
    chk("sram_addr", sram_addr, (w >= 0) ? addr[w] : '0);
    chk("sram_wdata", sram_wdata, (w >= 0) ? wd[w] : '0);
    chk("rs0_vld", rs0_vld, !rst && ov[0]);
    chk("rs1_vld", rs1_vld, !rst && ov[1]);
    chk("rs0_rdata", rs0_rdata, (!rst && ov[0]) ? od[0] : '0);
    chk("rs1_rdata", rs1_rdata, (!rst && ov[1]) ? od[1] : '0);
    @(posedge clk);
    if (rst) begin
      ov = '{1'b0, 1'b0};
      last = 1'b1;
    end else begin
      for (int i = 0; i < 2; i++)
        if (tk[i]) ov[i] = 1'b0;
      if (w >= 0) begin
        if (wen[w]) rmem[int'(addr[w])] = wd[w];
        else begin
          ov[w] = 1'b1;
          od[w] = rget(addr[w]);
        end
        last = (w == 1);
      end
    end
    #1;
    if (w >= 0) vld[w] = 1'b0;
  endtask

  task automatic setrq(int p, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
    vld[p]  = 1'b1;
    wen[p]  = we;
    addr[p] = a;
    wd[p]   = d;
  endtask

  initial begin
    rst = 1'b1;
    vld = 2'b11; wen = 2'b00; rsr = 2'b11;
    addr[0] = 15'h10; addr[1] = 15'h20;
    wd[0] = 32'h1111; wd[1] = 32'h2222;
    repeat (3) tick();
    rst = 1'b0;
    vld = 2'b00;
    tick();

    // Write then held read while the other port reads its own word
    setrq(0, 1'b1, 15'h5, 32'hDEAD_BEEF);
    tick();
    setrq(0, 1'b0, 15'h5, '0);
    setrq(1, 1'b0, 15'h6, '0);
    rsr = 2'b10;
    repeat (4) begin
      tick();
      #1;
      if (ov[0]) chk("hold_rdata0", rs0_rdata, 32'hDEAD_BEEF);
      if (ov[1]) chk("p1_rdata", rs1_rdata, 32'h1234_5678);
    end
    rsr = 2'b11;
    repeat (2) tick();

    // New read waits behind a held response, issues on the take cycle
    rsr = 2'b00;
    vld = 2'b00;
    setrq(0, 1'b0, 15'h1, '0);
    tick();
    tick();
    setrq(0, 1'b0, 15'h2, '0);
    tick();
    #1;
    chk("pend_vld", vld[0], 1'b1);
    chk("hold_vld", rs0_vld, 1'b1);
    rsr = 2'b01;
    tick();
    #1;
    chk("cont_vld", rs0_vld, 1'b1);
    rsr = 2'b11;
    repeat (2) tick();

    // Reset drops an outstanding port 1 response
    setrq(1, 1'b0, 15'h3, '0);
    tick();
    rst = 1'b1;
    vld = 2'b00;
    tick();
    rst = 1'b0;
    repeat (2) tick();
    setrq(0, 1'b0, 15'h10, '0);
    setrq(1, 1'b0, 15'h20, '0);
    #1;
    chk("first_win", rq0_rdy, 1'b1);
    tick();

    // Continuous contention with responses always taken
    repeat (4) begin
      setrq(0, 1'b0, 15'h10, '0);
      setrq(1, 1'b0, 15'h20, '0);
      tick();
    end
    vld = 2'b00;
    repeat (2) tick();

    // Random traffic
    repeat (600) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < 2; i++) begin
        if (!vld[i] && $urandom_range(0, 2) != 0)
          setrq(i, $urandom_range(0, 3) == 0,
                AW'($urandom_range(0, 7)), $urandom);
        rsr[i] = ($urandom_range(0, 2) != 0);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
